ysyx_23060124_ifu: RTL and testbench



---
 rtl/ysyx_23060124_ifu_pkg.sv | 14 +
 rtl/ysyx_23060124_ifu.sv | 113 +++++++++++
 tb/tb_ysyx_23060124_ifu.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060124_ifu_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch unit.
package ysyx_23060124_ifu_pkg;

    localparam int          IFU_ISA_WIDTH = 32;
    localparam logic [31:0] IFU_NOP_INST  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_AR   = 2'd1,
        IFU_R    = 2'd2,
        IFU_OUT  = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ysyx_23060124_ifu.sv
// Instruction fetch unit: issues one AR/R read per PC and hands the tagged
// instruction word to decode. Misaligned PCs and bus errors turn into a NOP
// flagged with o_err. At most one fetch is in flight.
module ysyx_23060124_ifu
    import ysyx_23060124_ifu_pkg::*;
#(
    parameter int                   ISA_WIDTH = IFU_ISA_WIDTH,
    parameter logic [ISA_WIDTH-1:0] NOP_INST  = IFU_NOP_INST
) (
    input  logic                 clk,
    input  logic                 i_rst_ifu_n,
    input  logic [ISA_WIDTH-1:0] i_pc,
    input  logic                 i_pc_update,
    output logic [ISA_WIDTH-1:0] o_araddr,
    output logic                 o_arvalid,
    input  logic                 i_arready,
    input  logic [ISA_WIDTH-1:0] i_rdata,
    input  logic [1:0]           i_rresp,
    input  logic                 i_rvalid,
    output logic                 o_rready,
    output logic [ISA_WIDTH-1:0] o_ins,
    output logic [ISA_WIDTH-1:0] o_ins_pc,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_err,
    output logic                 o_busy
);

    ifu_state_e           state_q;
    ifu_state_e           state_d;
    logic                 start_pend;
    logic                 upd_pend;
    logic [ISA_WIDTH-1:0] addr_q;
    logic                 trigger;
    logic                 misaligned;

    // The first fetch after reset needs no pulse; later ones come from the PC unit,
    // either live or remembered while the unit was busy.
    assign trigger    = start_pend | upd_pend | i_pc_update;
    assign misaligned = |i_pc[1:0];
    assign o_araddr   = addr_q;

    // State register
    always_ff @(posedge clk or negedge i_rst_ifu_n) begin
        if (!i_rst_ifu_n) begin
            state_q <= IFU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; a misaligned PC skips the bus entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IFU_IDLE: if (trigger)   state_d = misaligned ? IFU_OUT : IFU_AR;
            IFU_AR:   if (i_arready) state_d = IFU_R;
            IFU_R:    if (i_rvalid)  state_d = IFU_OUT;
            IFU_OUT:  if (i_ready)   state_d = IFU_IDLE;
            default:                 state_d = IFU_IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the state
    always_comb begin
        o_arvalid = (state_q == IFU_AR);
        o_rready  = (state_q == IFU_R);
        o_valid   = (state_q == IFU_OUT);
        o_busy    = (state_q != IFU_IDLE);
    end

    // Pending-fetch flags: pulses seen while busy collapse into one deferred fetch
    always_ff @(posedge clk or negedge i_rst_ifu_n) begin
        if (!i_rst_ifu_n) begin
            start_pend <= 1'b1;
            upd_pend   <= 1'b0;
        end else if (state_q == IFU_IDLE) begin
            if (trigger) begin
                start_pend <= 1'b0;
                upd_pend   <= 1'b0;
            end
        end else if (i_pc_update) begin
            upd_pend <= 1'b1;
        end
    end

    // Fetch address is sampled only when leaving IDLE, so it stays stable for AR
    always_ff @(posedge clk or negedge i_rst_ifu_n) begin
        if (!i_rst_ifu_n) begin
            addr_q <= '0;
        end else if ((state_q == IFU_IDLE) && trigger) begin
            addr_q <= i_pc;
        end
    end

    // Result registers, loaded on a misaligned trigger or on read data; held through OUT
    always_ff @(posedge clk or negedge i_rst_ifu_n) begin
        if (!i_rst_ifu_n) begin
            o_ins    <= NOP_INST;
            o_ins_pc <= '0;
            o_err    <= 1'b0;
        end else if ((state_q == IFU_IDLE) && trigger && misaligned) begin
            o_ins    <= NOP_INST;
            o_ins_pc <= i_pc;
            o_err    <= 1'b1;
        end else if ((state_q == IFU_R) && i_rvalid) begin
            o_ins    <= (i_rresp == 2'b00) ? i_rdata : NOP_INST;
            o_ins_pc <= addr_q;
            o_err    <= (i_rresp != 2'b00);
        end
    end

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// Bench for the instruction fetch unit: a responsive memory/decode model with
// programmable stalls, an expectation queue built from the fetch rules, and a
// per-cycle checker of bus requests and delivered instructions.
module tb_ysyx_23060124_ifu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_pc;
    logic        i_pc_update;
    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        o_rready;
    logic [31:0] o_ins;
    logic [31:0] o_ins_pc;
    logic        o_valid;
    logic        i_ready;
    logic        o_err;
    logic        o_busy;

    always #5 clk = ~clk;

    ysyx_23060124_ifu dut (
        .clk        (clk),
        .i_rst_ifu_n(rst_n),
        .i_pc       (i_pc),
        .i_pc_update(i_pc_update),
        .o_araddr   (o_araddr),
        .o_arvalid  (o_arvalid),
        .i_arready  (i_arready),
        .i_rdata    (i_rdata),
        .i_rresp    (i_rresp),
        .i_rvalid   (i_rvalid),
        .o_rready   (o_rready),
        .o_ins      (o_ins),
        .o_ins_pc   (o_ins_pc),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_err      (o_err),
        .o_busy     (o_busy)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_ar[$];
    int n_tests = 0;
    int n_fail  = 0;
    int ar_delay = 0;
    int r_delay = 0;
    int rdy_delay = 0;
    bit resp_err = 1'b0;
    int ar_hs = 0;
    int r_hs = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0297 : {a[15:0], 16'h0033};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // What a fetch of pc must deliver: aligned PCs read memory, others become a flagged NOP
    task automatic expect_fetch(input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        if (pc[1:0] != 2'b00) begin
            e.ins = NOP;
            e.err = 1'b1;
        end else begin
            exp_ar.push_back(pc);
            e.ins = resp_err ? NOP : mem_word(pc);
            e.err = resp_err;
        end
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] pc);
        i_pc = pc;
        i_pc_update = 1'b1;
        @(posedge clk); #1;
        i_pc_update = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp_ar.size() != 0 || o_busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d fetches still pending after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
            exp_ar.delete();
        end
    endtask

    // Memory and decode responder with programmable stall counts
    initial begin
        int ac = 0;
        int rc = 0;
        int vc = 0;
        logic [31:0] la = '0;
        i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_rresp = 2'b00; i_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            i_arready = 1'b0; i_rvalid = 1'b0; i_ready = 1'b0;
            if (!rst_n) begin
                ac = 0; rc = 0; vc = 0;
            end else begin
                if (o_arvalid) begin
                    if (ac >= ar_delay) begin
                        i_arready = 1'b1; la = o_araddr; ac = 0; ar_hs++;
                    end else ac++;
                end
                if (o_rready) begin
                    if (rc >= r_delay) begin
                        i_rvalid = 1'b1; i_rresp = resp_err ? 2'b10 : 2'b00;
                        i_rdata = mem_word(la); rc = 0; r_hs++;
                    end else rc++;
                end
                if (o_valid) begin
                    if (vc >= rdy_delay) begin
                        i_ready = 1'b1; vc = 0;
                    end else vc++;
                end
            end
        end
    end

    // Per-cycle checker: requests and deliveries against the expectation queues
    initial begin
        logic        pa = 1'b0;
        logic [31:0] paddr = '0;
        logic        pv = 1'b0;
        exp_t        pe;
        exp_t        e;
        pe.pc = '0; pe.ins = '0; pe.err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pa = 1'b0; pv = 1'b0;
                continue;
            end
            check1("busy_idle", o_busy, o_arvalid | o_rready | o_valid);
            if (o_arvalid) begin
                if (pa) check("araddr_stable", o_araddr, paddr);
                if (i_arready) begin
                    if (exp_ar.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_ar: araddr %h, required no request", o_araddr);
                    end else check("araddr", o_araddr, exp_ar.pop_front());
                    pa = 1'b0;
                end else begin
                    pa = 1'b1; paddr = o_araddr;
                end
            end else pa = 1'b0;
            if (o_valid) begin
                if (pv) begin
                    check("ins_stable", o_ins, pe.ins);
                    check("ins_pc_stable", o_ins_pc, pe.pc);
                end
                if (i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_out: ins %h pc %h, required no delivery", o_ins, o_ins_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("ins", o_ins, e.ins);
                        check("ins_pc", o_ins_pc, e.pc);
                        check1("err", o_err, e.err);
                    end
                    pv = 1'b0;
                end else begin
                    pv = 1'b1; pe.ins = o_ins; pe.pc = o_ins_pc; pe.err = o_err;
                end
            end else pv = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        int h0;
        int r0;
        int n;
        rst_n = 1'b0;
        i_pc = 32'h8000_0000;
        i_pc_update = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_arvalid", o_arvalid, 1'b0);
        check1("rst_rready", o_rready, 1'b0);
        check1("rst_valid", o_valid, 1'b0);
        check1("rst_err", o_err, 1'b0);
        check1("rst_busy", o_busy, 1'b0);
        check("rst_araddr", o_araddr, 32'h0);
        check("rst_ins", o_ins, NOP);
        check("rst_ins_pc", o_ins_pc, 32'h0);

        // Fetch after reset release with zero-wait memory
        expect_fetch(32'h8000_0000);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check1("c1_arvalid", o_arvalid, 1'b1);
        check("c1_araddr", o_araddr, 32'h8000_0000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check1("c3_valid", o_valid, 1'b1);
        check("c3_ins", o_ins, 32'h0000_0297);
        check("c3_ins_pc", o_ins_pc, 32'h8000_0000);
        check1("c3_err", o_err, 1'b0);
        @(posedge clk); #1;
        wait_done("first", 50);

        // Stalls on every channel
        ar_delay = 3; r_delay = 2; rdy_delay = 4;
        h0 = ar_hs; r0 = r_hs;
        expect_fetch(32'h8000_0100);
        fetch(32'h8000_0100);
        wait_done("stall", 100);
        check("stall_ar_count", ar_hs - h0, 1);
        check("stall_r_count", r_hs - r0, 1);
        ar_delay = 0; r_delay = 0; rdy_delay = 0;

        // Misaligned PC: no bus request, flagged NOP on the next cycle
        expect_fetch(32'h8000_0002);
        i_pc = 32'h8000_0002;
        i_pc_update = 1'b1;
        @(posedge clk); #1;
        i_pc_update = 1'b0;
        @(negedge clk);
        check1("mis_arvalid", o_arvalid, 1'b0);
        check1("mis_valid", o_valid, 1'b1);
        check("mis_ins", o_ins, 32'h0000_0013);
        check1("mis_err", o_err, 1'b1);
        check("mis_ins_pc", o_ins_pc, 32'h8000_0002);
        @(posedge clk); #1;
        wait_done("misaligned", 50);

        // Bus error response, then a normal fetch at the top of the address space
        resp_err = 1'b1;
        expect_fetch(32'h8000_0200);
        fetch(32'h8000_0200);
        wait_done("rresp_err", 50);
        resp_err = 1'b0;
        expect_fetch(32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC);
        wait_done("after_err", 50);

        // Two pulses while waiting for read data collapse into one later fetch
        r_delay = 6;
        h0 = ar_hs;
        expect_fetch(32'h8000_0300);
        fetch(32'h8000_0300);
        n = 0;
        while (!o_rready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check1("pend_in_r", o_rready, 1'b1);
        expect_fetch(32'h8000_0010);
        fetch(32'h8000_0004);
        fetch(32'h8000_0010);
        wait_done("collapse", 100);
        check("collapse_ar_count", ar_hs - h0, 2);
        r_delay = 0;

        // Reset in the middle of an address phase
        ar_delay = 10;
        expect_fetch(32'h8000_0400);
        fetch(32'h8000_0400);
        check1("pre_rst_arvalid", o_arvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("async_rst_arvalid", o_arvalid, 1'b0);
        check1("async_rst_busy", o_busy, 1'b0);
        check("async_rst_araddr", o_araddr, 32'h0);
        exp_q.delete();
        exp_ar.delete();
        ar_delay = 0;
        i_pc = 32'h8000_0500;
        @(posedge clk); #1;
        expect_fetch(32'h8000_0500);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check1("rst_refetch_arvalid", o_arvalid, 1'b1);
        check("rst_refetch_araddr", o_araddr, 32'h8000_0500);
        @(posedge clk); #1;
        wait_done("refetch", 50);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
